word_ram: RTL and testbench

//  Parametrised single-port synchronous RAM built from word-wide storage rows.
//  It generalises the 4-bit binary-cell word to WIDTH x DEPTH.

---
 rtl/word_ram_pkg.sv | 20 ++
 rtl/word_ram_if.sv | 31 +++
 rtl/word_ram_mem_row.sv | 20 ++
 rtl/word_ram.sv | 128 ++++++++++++
 tb/tb_word_ram.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/word_ram_pkg.sv
// Shared types and constants for word_ram: FSM state encoding, access-direction
// constants and a ceil-log2 helper used to size addresses.
package word_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/word_ram_if.sv
// Request/response bundle for word_ram; master drives requests, slave (the RAM)
// returns read data, valid strobe, busy and parity error.
interface word_ram_if
  import word_ram_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 16
);

  localparam int unsigned ADDR_W = clog2(DEPTH);

  logic              select;
  logic              read_write;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  in;
  logic [WIDTH-1:0]  out;
  logic              out_valid;
  logic              busy;
  logic              parity_err;

  modport master (
    output select, read_write, addr, in,
    input  out, out_valid, busy, parity_err
  );

  modport slave (
    input  select, read_write, addr, in,
    output out, out_valid, busy, parity_err
  );

endinterface

// File: rtl/word_ram_mem_row.sv
// One storage row of word_ram: a W-bit register with its own write enable.
// Deliberately not reset; the top-level zero-fill sequencer clears it.
module mem_row #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] word;

  always_ff @(posedge clk) begin
    if (we) word <= d;
  end

  assign q = word;

endmodule

// File: rtl/word_ram.sv
// Single-port WIDTH x DEPTH synchronous RAM with registered read, valid strobe
// and post-reset zero fill. Optional even parity per row: WORD_RAM_PARITY_EN.
module word_ram
  import word_ram_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  word_ram_if.slave      bus
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
`ifdef WORD_RAM_PARITY_EN
  localparam int unsigned ROW_W = WIDTH + 1;
`else
  localparam int unsigned ROW_W = WIDTH;
`endif
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t             state;
  logic [ADDR_W-1:0]  cnt;
  logic [ROW_W-1:0]   row_q [DEPTH];
  logic [DEPTH-1:0]   row_we;
  logic [ROW_W-1:0]   wr_row;
  logic [ROW_W-1:0]   rd_row;
  logic               req_wr;
  logic               req_rd;
  logic               rd_perr;
  logic [WIDTH-1:0]   out_r;
  logic               out_valid_r;
  logic               busy_r;
  logic               parity_err_r;

  always_comb begin
    req_wr = (state == ST_IDLE) && bus.select && (bus.read_write == RW_WRITE);
    req_rd = (state == ST_IDLE) && bus.select && (bus.read_write == RW_READ);
  end

  // INIT overrides the bus: the fill counter addresses the row and data is zero.
  always_comb begin
    wr_row = '0;
    if (state == ST_IDLE) begin
`ifdef WORD_RAM_PARITY_EN
      wr_row = {^bus.in, bus.in};
`else
      wr_row = bus.in;
`endif
    end
  end

  always_comb begin
    row_we = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (state == ST_INIT) row_we[i] = (cnt == ADDR_W'(i));
      else                  row_we[i] = req_wr && (bus.addr == ADDR_W'(i));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_rows
    mem_row #(.W(ROW_W)) u_row (
      .clk (clk),
      .we  (row_we[g]),
      .d   (wr_row),
      .q   (row_q[g])
    );
  end

  // Addresses beyond DEPTH match no row and read as all-zero.
  always_comb begin
    rd_row = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (bus.addr == ADDR_W'(i)) rd_row = row_q[i];
    end
  end

`ifdef WORD_RAM_PARITY_EN
  assign rd_perr = rd_row[WIDTH] != (^rd_row[WIDTH-1:0]);
`else
  assign rd_perr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_INIT;
      cnt          <= '0;
      busy_r       <= 1'b1;
      out_r        <= '0;
      out_valid_r  <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      out_valid_r  <= 1'b0;
      parity_err_r <= 1'b0;
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (req_rd) begin
            out_r        <= rd_row[WIDTH-1:0];
            out_valid_r  <= 1'b1;
            parity_err_r <= rd_perr;
          end
        end
        default: begin
          state  <= ST_INIT;
          cnt    <= '0;
          busy_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.out        = out_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.busy       = busy_r;
`ifdef WORD_RAM_PARITY_EN
  assign bus.parity_err = parity_err_r;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_word_ram.sv
// Directed bench for word_ram: a 4x16 instance for the main checks and a 4x12
// instance for out-of-range addressing on a non-power-of-two depth.
module tb_word_ram;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  word_ram_if #(.WIDTH(4), .DEPTH(16)) bus  ();
  word_ram_if #(.WIDTH(4), .DEPTH(12)) bus2 ();

  word_ram #(.WIDTH(4), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  word_ram #(.WIDTH(4), .DEPTH(12)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rw, input logic [3:0] a, input logic [3:0] d);
    bus.select = 1'b1; bus.read_write = rw; bus.addr = a; bus.in = d;
  endtask

  task automatic req2(input logic rw, input logic [3:0] a, input logic [3:0] d);
    bus2.select = 1'b1; bus2.read_write = rw; bus2.addr = a; bus2.in = d;
  endtask

  initial begin
    int n;
    int n2;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.select = 1'b0;  bus.read_write = 1'b0;  bus.addr = '0;  bus.in = '0;
    bus2.select = 1'b0; bus2.read_write = 1'b0; bus2.addr = '0; bus2.in = '0;
    step();
    step();

    // Reset values
    check("rst_out",        bus.out,        0);
    check("rst_out_valid",  bus.out_valid,  0);
    check("rst_busy",       bus.busy,       1);
    check("rst_parity_err", bus.parity_err, 0);
    check("rst_busy2",      bus2.busy,      1);

    // Write attempted throughout INIT must be ignored
    req(1'b0, 4'd5, 4'hF);
    rst = 1'b0;
    n = 0; n2 = 0;
    while (bus.busy && n < 40) begin
      if (bus2.busy) n2++;
      step();
      n++;
    end
    bus.select = 1'b0;
    check("busy_cycles",   n,  16);
    check("busy_cycles12", n2, 12);
    check("init_no_valid", bus.out_valid, 0);

    // Every word reads zero, one result per cycle
    for (int i = 0; i < 16; i++) begin
      req(1'b1, 4'(i), 4'h0);
      step();
      check("init_read_valid", bus.out_valid, 1);
      check("init_read_data",  bus.out,       0);
    end
    bus.select = 1'b0;
    step();
    check("idle_no_valid", bus.out_valid, 0);

    // Write then read next cycle
    req(1'b0, 4'd3, 4'hA);
    step();
    check("wr_no_valid", bus.out_valid, 0);
    check("wr_out_hold", bus.out,       0);
    req(1'b1, 4'd3, 4'h0);
    step();
    check("raw_valid", bus.out_valid, 1);
    check("raw_data",  bus.out,       4'hA);
    req(1'b0, 4'd0, 4'h5);
    step();
    req(1'b0, 4'd15, 4'hC);
    step();
    req(1'b1, 4'd0, 4'h0);
    step();
    check("rd0", bus.out, 4'h5);
    req(1'b1, 4'd7, 4'h0);
    step();
    check("rd7", bus.out, 4'h0);
    req(1'b1, 4'd15, 4'h0);
    step();
    check("rd15",       bus.out,       4'hC);
    check("rd15_valid", bus.out_valid, 1);
    bus.select = 1'b0;
    step();
    check("hold_out",      bus.out,       4'hC);
    check("hold_no_valid", bus.out_valid, 0);

    // Out-of-range address on the 12-deep instance
    req2(1'b0, 4'd1, 4'h6);
    step();
    req2(1'b0, 4'd13, 4'h7);
    step();
    req2(1'b0, 4'd11, 4'hB);
    step();
    req2(1'b1, 4'd1, 4'h0);
    step();
    check("d12_rd1", bus2.out, 4'h6);
    req2(1'b1, 4'd13, 4'h0);
    step();
    check("d12_rd13",       bus2.out,       4'h0);
    check("d12_rd13_valid", bus2.out_valid, 1);
    req2(1'b1, 4'd1, 4'h0);
    step();
    check("d12_rd1_again", bus2.out, 4'h6);
    req2(1'b1, 4'd11, 4'h0);
    step();
    check("d12_rd11", bus2.out, 4'hB);
    bus2.select = 1'b0;

    // Reset mid-INIT restarts the fill
    req(1'b0, 4'd12, 4'h9);
    step();
    req(1'b1, 4'd12, 4'h0);
    step();
    check("pre_rst_rd12", bus.out, 4'h9);
    bus.select = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_out",   bus.out,       0);
    check("async_rst_busy",  bus.busy,      1);
    check("async_rst_valid", bus.out_valid, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("busy_mid_init", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_init_busy", bus.busy, 1);
    rst = 1'b0;
    n = 0;
    while (bus.busy && n < 40) begin
      step();
      n++;
    end
    check("busy_cycles_restart", n, 16);
    req(1'b1, 4'd12, 4'h0);
    step();
    check("post_rst_rd12", bus.out,       0);
    check("post_rst_vld",  bus.out_valid, 1);
    req(1'b1, 4'd3, 4'h0);
    step();
    check("post_rst_rd3", bus.out, 0);

    // Parity: corrupted row flags an error, clean rows do not
    req(1'b0, 4'd2, 4'h3);
    step();
`ifdef WORD_RAM_PARITY_EN
    force dut.g_rows[2].u_row.word = 5'b1_0011;
`endif
    req(1'b1, 4'd2, 4'h0);
    step();
    check("par_rd2_data",  bus.out,       4'h3);
    check("par_rd2_valid", bus.out_valid, 1);
`ifdef WORD_RAM_PARITY_EN
    check("par_rd2_err",   bus.parity_err, 1);
    release dut.g_rows[2].u_row.word;
`else
    check("par_rd2_err",   bus.parity_err, 0);
`endif
    req(1'b1, 4'd3, 4'h0);
    step();
    check("par_clean_err", bus.parity_err, 0);
    bus.select = 1'b0;
    step();
    check("par_idle_err",  bus.parity_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
